// File: rtl/hvsync_decoder.sv
// hvsync_decoder
//   Receiving side of the VGA timing bundle. Samples hsync/vsync/display
//   from a sync source, recovers the pixel position, verifies the timing
//   against the configured parameter set, declares lock after one clean
//   frame and counts timing violations.
//
// Ports
//   clk          system clock
//   reset        synchronous, active-high reset
//   pix_en       pixel strobe; sampling and counting only when high
//   hsync_in     active-low horizontal sync
//   vsync_in     active-low vertical sync
//   display_in   display-enable from the source
//   hpos_rx      recovered horizontal position
//   vpos_rx      recovered vertical position
//   display_rx   recovered position lies in the visible area
//   locked       timing verified
//   frame_start  one-cycle pulse when locked and position becomes (0,0)
//   sync_err     one-cycle pulse per detected violation
//   err_count    saturating violation count
module hvsync_decoder #(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_BOTTOM  = 10,
  parameter int V_SYNC    = 2,
  parameter int V_TOP     = 33
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pix_en,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic       display_in,
  output logic [9:0] hpos_rx,
  output logic [9:0] vpos_rx,
  output logic       display_rx,
  output logic       locked,
  output logic       frame_start,
  output logic       sync_err,
  output logic [7:0] err_count
);

  localparam int H_SYNC_START = H_DISPLAY + H_FRONT;
  localparam int H_MAX        = H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1;
  localparam int V_SYNC_START = V_DISPLAY + V_BOTTOM;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;
  localparam int V_MAX        = V_DISPLAY + V_BOTTOM + V_SYNC + V_TOP - 1;

  localparam logic [9:0] H_DISP_C   = 10'(H_DISPLAY);
  localparam logic [9:0] V_DISP_C   = 10'(V_DISPLAY);
  localparam logic [9:0] H_SS_C     = 10'(H_SYNC_START);
  localparam logic [9:0] H_MAX_C    = 10'(H_MAX);
  localparam logic [9:0] H_SYNC_C   = 10'(H_SYNC);
  localparam logic [9:0] V_SS_C     = 10'(V_SYNC_START);
  localparam logic [9:0] V_RISE_C   = 10'(V_SYNC_END + 1);
  localparam logic [9:0] V_MAX_C    = 10'(V_MAX);
  localparam logic [9:0] HLOW_MAX_C = 10'd1023;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic       h_prev;
  logic       v_prev;
  logic [9:0] hlow;

  logic       h_fall;
  logic       h_rise;
  logic       v_fall;
  logic       v_rise;
  logic [9:0] nxt_h;
  logic [9:0] nxt_v;
  logic       nxt_disp;
  logic       violation;
  logic       frame_hit;
  logic [9:0] hpos_nxt;
  logic [9:0] vpos_nxt;
  logic [9:0] hlow_nxt;

  function automatic logic in_display(input logic [9:0] h, input logic [9:0] v);
    return (h < H_DISP_C) && (v < V_DISP_C);
  endfunction

  // Edge detection, freewheel prediction and timing checks for this sample
  always_comb begin
    h_fall    = h_prev & ~hsync_in;
    h_rise    = ~h_prev & hsync_in;
    v_fall    = v_prev & ~vsync_in;
    v_rise    = ~v_prev & vsync_in;
    nxt_h     = (hpos_rx == H_MAX_C) ? 10'd0 : hpos_rx + 10'd1;
    nxt_v     = vpos_rx;
    violation = 1'b0;
    hpos_nxt  = nxt_h;
    vpos_nxt  = vpos_rx;
    hlow_nxt  = hlow;

    if (hpos_rx == H_MAX_C) begin
      nxt_v = (vpos_rx == V_MAX_C) ? 10'd0 : vpos_rx + 10'd1;
    end else begin
      nxt_v = vpos_rx;
    end
    vpos_nxt = nxt_v;
    nxt_disp = in_display(nxt_h, nxt_v);

    if (state != SEARCH) begin
      // A simultaneous v_fall takes over the horizontal alignment, so the
      // h_fall position check is skipped in that case.
      if (h_fall && !v_fall && (nxt_h != H_SS_C)) begin
        violation = 1'b1;
      end else if (h_rise && (hlow != H_SYNC_C)) begin
        violation = 1'b1;
      end else if (v_fall && ((nxt_v != V_SS_C) || (nxt_h != 10'd0))) begin
        violation = 1'b1;
      end else if (v_rise && ((nxt_v != V_RISE_C) || (nxt_h != 10'd0))) begin
        violation = 1'b1;
      end else if (display_in != nxt_disp) begin
        violation = 1'b1;
      end else if ((nxt_h == H_SS_C) && !h_fall) begin
        violation = 1'b1;
      end else begin
        violation = 1'b0;
      end
    end else begin
      violation = 1'b0;
    end

    frame_hit = (state == LOCKED) && (nxt_h == 10'd0) && (nxt_v == 10'd0);

    // While searching (or on the sample that loses lock) the sync edges
    // re-align the counters; otherwise they simply freewheel.
    if ((state == SEARCH) || violation) begin
      if (v_fall) begin
        hpos_nxt = 10'd0;
        vpos_nxt = V_SS_C;
      end else if (h_fall) begin
        hpos_nxt = H_SS_C;
      end else begin
        hpos_nxt = nxt_h;
      end
    end else begin
      hpos_nxt = nxt_h;
    end

    // The falling-edge sample is itself the first low sample of the pulse.
    if (h_fall) begin
      hlow_nxt = 10'd1;
    end else if (!hsync_in && (hlow != HLOW_MAX_C)) begin
      hlow_nxt = hlow + 10'd1;
    end else begin
      hlow_nxt = hlow;
    end
  end

  // Next-state logic of the lock FSM
  always_comb begin
    state_nxt = state;
    case (state)
      SEARCH: begin
        if (v_fall) begin
          state_nxt = CHECK;
        end else begin
          state_nxt = SEARCH;
        end
      end
      CHECK: begin
        if (violation) begin
          state_nxt = SEARCH;
        end else if (v_fall) begin
          state_nxt = LOCKED;
        end else begin
          state_nxt = CHECK;
        end
      end
      LOCKED: begin
        if (violation) begin
          state_nxt = SEARCH;
        end else begin
          state_nxt = LOCKED;
        end
      end
      default: state_nxt = SEARCH;
    endcase
  end

  // Lock FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= SEARCH;
    end else if (pix_en) begin
      state <= state_nxt;
    end else begin
      state <= state;
    end
  end

  // Sample history, recovered position and status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      h_prev      <= 1'b0;
      v_prev      <= 1'b0;
      hlow        <= 10'd0;
      hpos_rx     <= 10'd0;
      vpos_rx     <= 10'd0;
      display_rx  <= 1'b0;
      locked      <= 1'b0;
      frame_start <= 1'b0;
      sync_err    <= 1'b0;
      err_count   <= 8'd0;
    end else begin
      frame_start <= 1'b0;
      sync_err    <= 1'b0;
      if (pix_en) begin
        h_prev      <= hsync_in;
        v_prev      <= vsync_in;
        hlow        <= hlow_nxt;
        hpos_rx     <= hpos_nxt;
        vpos_rx     <= vpos_nxt;
        display_rx  <= in_display(hpos_nxt, vpos_nxt);
        locked      <= (state_nxt == LOCKED);
        frame_start <= frame_hit;
        sync_err    <= violation;
        if (violation && (err_count != 8'hFF)) begin
          err_count <= err_count + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_hvsync_decoder.sv
// Testbench for hvsync_decoder using a reduced timing set so whole frames
// fit in a short run: 16 pixels per line, 9 lines per frame.
module tb_hvsync_decoder;

  localparam int HD  = 8;
  localparam int HF  = 2;
  localparam int HSW = 3;
  localparam int HB  = 3;
  localparam int VD  = 4;
  localparam int VB  = 1;
  localparam int VSW = 2;
  localparam int VTP = 2;
  localparam int HT  = HD + HF + HSW + HB;
  localparam int VT  = VD + VB + VSW + VTP;
  localparam int FT  = HT * VT;
  localparam int HSS = HD + HF;
  localparam int VSS = VD + VB;
  localparam int VSE = VSS + VSW - 1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pix_en = 1'b0;
  logic       hsync_in = 1'b1;
  logic       vsync_in = 1'b1;
  logic       display_in = 1'b0;
  logic [9:0] hpos_rx;
  logic [9:0] vpos_rx;
  logic       display_rx;
  logic       locked;
  logic       frame_start;
  logic       sync_err;
  logic [7:0] err_count;

  hvsync_decoder #(
    .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB),
    .V_DISPLAY(VD), .V_BOTTOM(VB), .V_SYNC(VSW), .V_TOP(VTP)
  ) dut (
    .clk(clk), .reset(reset), .pix_en(pix_en),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .display_in(display_in),
    .hpos_rx(hpos_rx), .vpos_rx(vpos_rx), .display_rx(display_rx),
    .locked(locked), .frame_start(frame_start), .sync_err(sync_err),
    .err_count(err_count)
  );

  always #10 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int check_en = 0;

  // generator state and fault injection
  int g = 0;
  int last_h = 0;
  int last_v = 0;
  int last_ln = 0;
  int fault_kind = 0;   // 1: stretch hsync by one pixel, 2: suppress hsync
  int fault_line = -1;

  // behavioural model: position kept as a linear pixel index in the frame
  int m_pos = 0, m_hprev = 0, m_vprev = 0, m_hlow = 0, m_mode = 0;
  int m_locked = 0, m_fs = 0, m_err = 0, m_disp = 0, m_cnt = 0;
  int n_fs = 0, n_serr = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // m_mode: 0 searching, 1 verifying first frame, 2 locked
  task automatic model_step();
    int nxt, nh, nv, hf, hr, vf, vr, bad, de_exp;
    if (reset) begin
      m_pos = 0; m_hprev = 0; m_vprev = 0; m_hlow = 0; m_mode = 0;
      m_locked = 0; m_fs = 0; m_err = 0; m_disp = 0; m_cnt = 0;
    end else begin
      m_fs = 0;
      m_err = 0;
      if (pix_en) begin
        nxt = (m_pos + 1) % FT;
        nh = nxt % HT;
        nv = nxt / HT;
        hf = (m_hprev == 1 && hsync_in == 1'b0) ? 1 : 0;
        hr = (m_hprev == 0 && hsync_in == 1'b1) ? 1 : 0;
        vf = (m_vprev == 1 && vsync_in == 1'b0) ? 1 : 0;
        vr = (m_vprev == 0 && vsync_in == 1'b1) ? 1 : 0;
        de_exp = (nh < HD && nv < VD) ? 1 : 0;
        bad = 0;
        if (m_mode != 0) begin
          if (hf == 1 && vf == 0 && nh != HSS) bad = 1;
          if (hr == 1 && m_hlow != HSW) bad = 1;
          if (vf == 1 && nxt != VSS * HT) bad = 1;
          if (vr == 1 && nxt != (VSE + 1) * HT) bad = 1;
          if (int'(display_in) != de_exp) bad = 1;
          if (nh == HSS && hf == 0) bad = 1;
        end
        if (m_mode == 2 && nxt == 0) m_fs = 1;
        if (m_mode == 0 || bad == 1) begin
          if (vf == 1) nxt = VSS * HT;
          else if (hf == 1) nxt = nv * HT + HSS;
        end
        if (bad == 1) begin
          m_err = 1;
          if (m_cnt < 255) m_cnt++;
          m_mode = 0;
        end else if (vf == 1) begin
          m_mode = (m_mode == 0) ? 1 : 2;
        end
        m_pos = nxt;
        m_locked = (m_mode == 2) ? 1 : 0;
        m_disp = ((nxt % HT) < HD && (nxt / HT) < VD) ? 1 : 0;
        if (hf == 1) m_hlow = 1;
        else if (hsync_in == 1'b0 && m_hlow < 1023) m_hlow++;
        m_hprev = int'(hsync_in);
        m_vprev = int'(vsync_in);
      end
    end
  endtask

  task automatic count_pulses();
    if (check_en != 0) begin
      if (frame_start) n_fs++;
      if (sync_err) n_serr++;
    end
  endtask

  always @(posedge clk) model_step();

  // compare every output with the model on every cycle
  always @(negedge clk) begin
    if (check_en != 0) begin
      chk("hpos_rx", int'(hpos_rx), m_pos % HT);
      chk("vpos_rx", int'(vpos_rx), m_pos / HT);
      chk("display_rx", int'(display_rx), m_disp);
      chk("locked", int'(locked), m_locked);
      chk("frame_start", int'(frame_start), m_fs);
      chk("sync_err", int'(sync_err), m_err);
      chk("err_count", int'(err_count), m_cnt);
    end
    count_pulses();
  end

  // one pix_en sample; returns at the negedge where its result is visible
  task automatic sample(input bit hs, input bit vs, input bit de);
    @(negedge clk);
    pix_en = 1'b1;
    hsync_in = hs;
    vsync_in = vs;
    display_in = de;
    @(negedge clk);
    pix_en = 1'b0;
  endtask

  task automatic gen_tick(input int n);
    for (int i = 0; i < n; i++) begin
      int h, v, ln;
      bit hs, vs, de;
      h = g % HT;
      ln = g / HT;
      v = ln % VT;
      hs = !(h >= HSS && h < HSS + HSW);
      if (fault_kind == 1 && ln == fault_line && h == HSS + HSW) hs = 1'b0;
      if (fault_kind == 2 && ln == fault_line) hs = 1'b1;
      vs = !(v >= VSS && v <= VSE);
      de = (h < HD) && (v < VD);
      last_h = h;
      last_v = v;
      last_ln = ln;
      g++;
      sample(hs, vs, de);
    end
  endtask

  // advance the generator until the vsync falling-edge sample has been taken
  task automatic run_to_vfall();
    int found;
    found = 0;
    for (int i = 0; i < 2 * FT && found == 0; i++) begin
      gen_tick(1);
      if (last_h == 0 && last_v == VSS) found = 1;
    end
    chk("vfall_reached", found, 1);
  endtask

  initial begin
    int base_fs, base_serr, found;

    // reset state
    repeat (3) @(negedge clk);
    check_en = 1;
    chk("rst_hpos", int'(hpos_rx), 0);
    chk("rst_vpos", int'(vpos_rx), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_err_count", int'(err_count), 0);
    chk("rst_display", int'(display_rx), 0);

    // 1: reset released mid-line with the generator running
    g = 3 * HT + 5;
    gen_tick(2);
    reset = 1'b0;
    base_serr = n_serr;
    run_to_vfall();
    chk("t1_check_not_locked", int'(locked), 0);
    run_to_vfall();
    chk("t1_locked", int'(locked), 1);
    for (int i = 0; i < FT; i++) begin
      gen_tick(1);
      chk("t1_hpos_track", int'(hpos_rx), last_h);
      chk("t1_vpos_track", int'(vpos_rx), last_v);
    end
    chk("t1_err_count", int'(err_count), 0);
    chk("t1_no_sync_err", n_serr - base_serr, 0);

    // 2: frame_start single-cycle pulse one clk after the (0,0) sample
    base_fs = n_fs;
    for (int i = 0; i < 2 * FT; i++) begin
      gen_tick(1);
      if (last_h == 0 && last_v == 0) begin
        chk("t2_fs_pulse", int'(frame_start), 1);
        @(negedge clk);
        chk("t2_fs_single", int'(frame_start), 0);
      end
    end
    chk("t2_fs_per_frame", n_fs - base_fs, 2);

    // 3: one hsync pulse stretched by one pixel
    base_serr = n_serr;
    fault_kind = 1;
    fault_line = g / HT + 1;
    gen_tick(2 * HT);
    fault_kind = 0;
    chk("t3_err_count", int'(err_count), 1);
    chk("t3_unlocked", int'(locked), 0);
    chk("t3_one_pulse", n_serr - base_serr, 1);
    run_to_vfall();
    chk("t3_check_not_locked", int'(locked), 0);
    run_to_vfall();
    chk("t3_relocked", int'(locked), 1);

    // 4: one hsync pulse suppressed; violation at predicted hpos HSS
    fault_kind = 2;
    fault_line = g / HT + 1;
    found = 0;
    for (int i = 0; i < 3 * HT && found == 0; i++) begin
      gen_tick(1);
      if (last_ln == fault_line && last_h == HSS) found = 1;
    end
    chk("t4_reached", found, 1);
    chk("t4_sync_err", int'(sync_err), 1);
    chk("t4_err_count", int'(err_count), 2);
    chk("t4_unlocked", int'(locked), 0);
    fault_kind = 0;
    run_to_vfall();
    run_to_vfall();
    chk("t4_relocked", int'(locked), 1);

    // 6: 300 counted violations saturate err_count, then reset clears it
    for (int i = 0; i < 300; i++) begin
      sample(1'b1, 1'b0, 1'b0);
      sample(1'b1, 1'b1, 1'b0);
      if (i == 199) chk("t6_count_202", int'(err_count), 202);
    end
    chk("t6_saturated", int'(err_count), 255);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("t6_rst_err_count", int'(err_count), 0);
    chk("t6_rst_locked", int'(locked), 0);
    chk("t6_rst_hpos", int'(hpos_rx), 0);
    chk("t6_rst_vpos", int'(vpos_rx), 0);

    // 5: syncs held low through reset release are not edges
    base_serr = n_serr;
    reset = 1'b1;
    sample(1'b0, 1'b0, 1'b0);
    sample(1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) sample(1'b0, 1'b0, 1'b0);
    chk("t5_hpos_free", int'(hpos_rx), 5);
    chk("t5_vpos_free", int'(vpos_rx), 0);
    chk("t5_display", int'(display_rx), 1);
    chk("t5_locked", int'(locked), 0);
    chk("t5_err_count", int'(err_count), 0);
    for (int i = 0; i < 4; i++) sample(1'b1, 1'b1, 1'b0);
    chk("t5_hpos_after", int'(hpos_rx), 9);
    chk("t5_still_search", int'(locked), 0);
    chk("t5_no_pulse", n_serr - base_serr, 0);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
